cache_fill_arbiter: RTL and testbench

- Multi-cycle memory controller for the pipelined WISC CPU.
- Shares one 4-cycle-latency unified memory between three requesters: I-cache miss fills, D-cache miss fills and D-side write-through stores.
- On a fill, it issues the eight word reads of a 16-byte block back-to-back, steers returned words into the owning cache's data array, then writes that cache's tag.
- Sits between the two caches and the memory model.

---
 rtl/cache_fill_arbiter.sv | 147 ++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one unified memory between I-fill, D-fill and
// D-side write-through stores; issues 8-word block reads, steers returns.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_miss/i_miss_addr         I-cache miss request (held until i_fill_done)
//   d_miss/d_miss_addr         D-cache miss request (held until d_fill_done)
//   d_wr_req/addr/data         store request (held until d_wr_ack)
//   mem_data_out/valid         memory read return
//   mem_en/wr/addr/data_in     memory command
//   fill_data/fill_word        returned word and its index in the block
//   i_/d_data_we, i_/d_tag_we  cache array write strobes
//   fill_tag_addr              latched block base for the tag write
//   i_/d_fill_done, d_wr_ack   completion pulses
//   busy                       controller not idle
module cache_fill_arbiter #(
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_data_we,
  output logic        d_data_we,
  output logic        i_tag_we,
  output logic        d_tag_we,
  output logic [15:0] fill_tag_addr,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_ack,
  output logic        busy
);

  if (MEM_LAT < 1 || BLK_WORDS != 8) begin : g_bad_cfg
    $error("cache_fill_arbiter: unsupported MEM_LAT/BLK_WORDS");
  end

  localparam logic [2:0] LAST = 3'(BLK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_TAG
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE, OWN_I, OWN_D
  } owner_t;

  state_t      r_state;
  owner_t      r_owner;
  logic        r_live;
  logic [15:0] r_base;
  logic [2:0]  r_issue_cnt;
  logic [2:0]  r_ret_cnt;

  logic w_idle_ok;
  logic w_st_gnt;
  logic w_d_gnt;
  logic w_i_gnt;
  logic w_issue;
  logic w_acc;
  logic w_tag;

  // r_live holds off grants for the first cycle after reset
  assign w_idle_ok = (r_state == S_IDLE) && r_live;
  assign w_st_gnt  = w_idle_ok && d_wr_req;
  assign w_d_gnt   = w_idle_ok && !d_wr_req && d_miss;
  assign w_i_gnt   = w_idle_ok && !d_wr_req && !d_miss && i_miss;
  assign w_issue   = (r_state == S_ISSUE);
  assign w_acc     = ((r_state == S_ISSUE) || (r_state == S_DRAIN))
                     && mem_data_valid;
  assign w_tag     = (r_state == S_TAG);

  assign mem_en      = w_st_gnt || w_issue;
  assign mem_wr      = w_st_gnt;
  assign mem_addr    = w_st_gnt ? d_wr_addr :
                       w_issue  ? r_base + {12'h0, r_issue_cnt, 1'b0} :
                                  16'h0;
  assign mem_data_in = w_st_gnt ? d_wr_data : 16'h0;
  assign d_wr_ack    = w_st_gnt;

  assign fill_data = w_acc ? mem_data_out : 16'h0;
  assign fill_word = w_acc ? r_ret_cnt : 3'h0;
  assign i_data_we = w_acc && (r_owner == OWN_I);
  assign d_data_we = w_acc && (r_owner == OWN_D);

  assign i_tag_we      = w_tag && (r_owner == OWN_I);
  assign d_tag_we      = w_tag && (r_owner == OWN_D);
  assign i_fill_done   = i_tag_we;
  assign d_fill_done   = d_tag_we;
  assign fill_tag_addr = w_tag ? r_base : 16'h0;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_live      <= 1'b0;
      r_base      <= 16'h0;
      r_issue_cnt <= 3'h0;
      r_ret_cnt   <= 3'h0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_d_gnt || w_i_gnt) begin
            r_owner     <= w_d_gnt ? OWN_D : OWN_I;
            r_base      <= (w_d_gnt ? d_miss_addr : i_miss_addr)
                           & 16'hFFF0;
            r_issue_cnt <= 3'h0;
            r_ret_cnt   <= 3'h0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_issue_cnt <= r_issue_cnt + 3'h1;
          if (r_issue_cnt == LAST) r_state <= S_DRAIN;
        end
        S_DRAIN: ;
        S_TAG: begin
          r_owner <= OWN_NONE;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // last return wins over the ISSUE->DRAIN step with a fast memory
      if (w_acc) begin
        r_ret_cnt <= r_ret_cnt + 3'h1;
        if (r_ret_cnt == LAST) r_state <= S_TAG;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle memory model.
// Checks the full output bundle every cycle against hand-built vectors.
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0;
  logic [15:0] i_miss_addr = 16'h0;
  logic        d_miss = 1'b0;
  logic [15:0] d_miss_addr = 16'h0;
  logic        d_wr_req = 1'b0;
  logic [15:0] d_wr_addr = 16'h0;
  logic [15:0] d_wr_data = 16'h0;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_data_we;
  logic        d_data_we;
  logic        i_tag_we;
  logic        d_tag_we;
  logic [15:0] fill_tag_addr;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        d_wr_ack;
  logic        busy;

  logic        inj_v = 1'b0;
  logic [15:0] inj_d = 16'h0;
  int n_run = 0;
  int n_fail = 0;

  cache_fill_arbiter #(.MEM_LAT(4), .BLK_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_data_we(i_data_we), .d_data_we(d_data_we),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
    .fill_tag_addr(fill_tag_addr),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory: read issued in cycle k returns in cycle k+4, data = addr^5A5A
  logic [3:0]  pv = 4'h0;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_data_valid = pv[3] | inj_v;
  assign mem_data_out   = inj_v ? inj_d :
                          pv[3] ? (pa[3] ^ 16'h5A5A) : 16'h0;

  logic [76:0] obs;
  assign obs = {busy, mem_en, mem_wr, mem_addr, mem_data_in,
                i_data_we, d_data_we, fill_word, fill_data,
                i_tag_we, d_tag_we, fill_tag_addr,
                i_fill_done, d_fill_done, d_wr_ack};

  localparam logic [76:0] ZERO = '0;

  function automatic logic [76:0] mk(
    input logic bz, en, wr, input logic [15:0] ad, di,
    input logic iwe, dwe, input logic [2:0] fw, input logic [15:0] fd,
    input logic itw, dtw, input logic [15:0] fta,
    input logic ifd, dfd, ack);
    return {bz, en, wr, ad, di, iwe, dwe, fw, fd,
            itw, dtw, fta, ifd, dfd, ack};
  endfunction

  // c = 0 grant, 1..8 issue, 5..12 returns, 13 tag
  function automatic logic [76:0] exp_fill(
    input int c, input logic dd, input logic [15:0] b);
    logic en, we, tg;
    logic [15:0] ad, fd;
    logic [2:0] fw;
    en = (c >= 1 && c <= 8);
    we = (c >= 5 && c <= 12);
    tg = (c == 13);
    ad = en ? b + 16'(2 * (c - 1)) : 16'h0;
    fw = we ? 3'(c - 5) : 3'h0;
    fd = we ? (b + 16'(2 * (c - 5))) ^ 16'h5A5A : 16'h0;
    return mk(c != 0, en, 1'b0, ad, 16'h0, we & ~dd, we & dd, fw, fd,
              tg & ~dd, tg & dd, tg ? b : 16'h0, tg & ~dd, tg & dd, 1'b0);
  endfunction

  function automatic logic [76:0] exp_st(
    input logic [15:0] a, input logic [15:0] d);
    return mk(1'b0, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 3'h0, 16'h0,
              1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic chk(input string tg, input logic [76:0] e);
    #1;
    n_run++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tg, obs, e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input string nm, input logic dd,
                         input logic [15:0] a, input int wr_at,
                         input int inj_at);
    logic [15:0] b;
    b = a & 16'hFFF0;
    for (int c = 0; c < 14; c++) begin
      if (c == wr_at) begin
        d_wr_req  = 1'b1;
        d_wr_addr = 16'h3002;
        d_wr_data = 16'hBEEF;
      end
      inj_v = (c == inj_at);
      inj_d = 16'hDEAD;
      chk($sformatf("%s c%0d", nm, c), exp_fill(c, dd, b));
      nxt();
    end
    inj_v = 1'b0;
    if (dd) d_miss = 1'b0;
    else    i_miss = 1'b0;
  endtask

  initial begin
    // reset state
    chk("rst low", ZERO);
    nxt();
    nxt();
    rst_n = 1'b1;
    chk("rst first", ZERO);
    nxt();

    // single I miss
    i_miss = 1'b1;
    i_miss_addr = 16'h0046;
    do_fill("ione", 1'b0, 16'h0046, -1, -1);
    chk("idle1", ZERO);
    nxt();

    // simultaneous misses: D wins
    i_miss = 1'b1;
    i_miss_addr = 16'h0010;
    d_miss = 1'b1;
    d_miss_addr = 16'h2008;
    do_fill("dfirst", 1'b1, 16'h2008, -1, -1);
    do_fill("ithen", 1'b0, 16'h0010, -1, -1);

    // store during D fill waits for IDLE, then pending I miss
    d_miss = 1'b1;
    d_miss_addr = 16'h4000;
    i_miss = 1'b1;
    i_miss_addr = 16'h0100;
    do_fill("dst", 1'b1, 16'h4000, 3, -1);
    chk("store", exp_st(16'h3002, 16'hBEEF));
    nxt();
    d_wr_req = 1'b0;
    do_fill("iafter", 1'b0, 16'h0100, -1, -1);

    // reset at 5th ISSUE cycle
    i_miss = 1'b1;
    i_miss_addr = 16'h0200;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("pre-rst c%0d", c), exp_fill(c, 1'b0, 16'h0200));
      nxt();
    end
    rst_n = 1'b0;
    i_miss = 1'b0;
    chk("rst c5", ZERO);
    nxt();
    chk("rst c6", ZERO);
    nxt();
    rst_n = 1'b1;
    d_wr_req = 1'b1;
    d_wr_addr = 16'h1234;
    d_wr_data = 16'h0001;
    chk("post-rst first", ZERO);
    nxt();
    chk("post-rst store", exp_st(16'h1234, 16'h0001));
    nxt();
    d_wr_req = 1'b0;
    chk("post-rst idle", ZERO);
    nxt();

    // wrapping block
    d_miss = 1'b1;
    d_miss_addr = 16'hFFFA;
    do_fill("wrap", 1'b1, 16'hFFFA, -1, -1);

    // spurious return in IDLE, 9th return in TAG
    inj_v = 1'b1;
    inj_d = 16'h1111;
    chk("spur idle", ZERO);
    nxt();
    inj_v = 1'b0;
    i_miss = 1'b1;
    i_miss_addr = 16'h0300;
    do_fill("tag9", 1'b0, 16'h0300, -1, 13);
    chk("after tag", ZERO);
    nxt();
    i_miss = 1'b1;
    i_miss_addr = 16'h0520;
    do_fill("again", 1'b0, 16'h0520, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
